fuzz_vector_player: RTL
=======================

Name: fuzz_vector_player

Overview:
- Synthesizable successor to the per-design fixed-vector bench.
- Holds a loadable buffer of stimulus vectors and replays them onto a DUT input bus, one vector per HOLD-cycle slot.
- Samples two response buses: identity model and synthesized netlist.
- Compresses the identity response into a MISR signature and counts/locates response mismatches.
- Sits between the fuzz driver and the pair of DUT instances in the equivalence harness.

Parameters:
- IN_W, 63: width of one stimulus vector (concatenated DUT inputs).
- OUT_W, 421: width of each response bus.
- DEPTH, 32: stimulus buffer entries (≥2).
- HOLD, 1: clock cycles each vector is driven (≥1).
- SIG_W, 32: MISR width.
- POLY, 32'h04C11DB7: MISR feedback polynomial (low SIG_W bits used).

Ports:
- clk, in, 1: clock, all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- load_valid, in, 1: load word present.
- load_ready, out, 1: buffer accepts a word.
- load_data, in, IN_W: stimulus vector to append.
- clear, in, 1: empty the buffer and return to IDLE.
- start, in, 1: begin replay.
- stim, out, IN_W: vector driven to both DUTs.
- resp_a, in, OUT_W: identity-model response.
- resp_b, in, OUT_W: synthesized-netlist response.
- busy, out, 1: replay in progress.
- done, out, 1: replay complete, results valid.
- vec_count, out, $clog2(DEPTH+1): vectors loaded.
- mm_count, out, $clog2(DEPTH+1): mismatching samples in the last run.
- mm_found, out, 1: at least one mismatch.
- mm_idx, out, $clog2(DEPTH): index of the first mismatch.
- sig, out, SIG_W: MISR signature of resp_a.

Behaviour:
- Reset values: stim=0, busy=0, done=0, vec_count=0, mm_count=0, mm_found=0, mm_idx=0, sig=0, load_ready=1, state=IDLE. Buffer RAM contents are not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - load_ready = (vec_count < DEPTH).
  - A load_valid&&load_ready handshake writes buf[vec_count] and increments vec_count.
  - load_valid when full: ignored, no wrap.
  - start with vec_count>0 → RUN. start with vec_count==0 is ignored.
  - clear → vec_count=0.
  - start and clear in the same cycle: clear wins, stay in IDLE.
- Entering RUN:
  - idx=0, hold=0, sig=all-ones seed, mm_count=0, mm_found=0, mm_idx=0.
  - stim register loads buf[0] on the same edge.
- RUN:
  - busy=1, load_ready=0.
  - stim holds buf[idx] for exactly HOLD cycles.
  - On the cycle where hold==HOLD-1, resp_a/resp_b are sampled at the next edge.
  - MISR update: sig ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(resp_a). fold = XOR of resp_a split into SIG_W-bit chunks from bit 0, top chunk zero-padded.
  - If resp_a != resp_b: mm_count++. If mm_found==0, also set mm_found=1 and mm_idx=idx.
  - Then idx++, hold=0, stim←buf[idx+1].
  - After sampling idx==vec_count-1 → DONE; stim keeps the last vector.
  - RUN lasts exactly vec_count*HOLD cycles. done rises on the edge that takes the last sample.
- DONE:
  - done=1, busy=0.
  - Results stable until the next start.
  - start → RUN, replaying the same buffer with a fresh seed.
  - clear → IDLE with vec_count=0, done=0. Results are retained until the next start.
  - load_ready=0 in DONE.
- start and clear are ignored in RUN. clear is the only abort path besides rst.
- rst mid-run: immediate return to reset values on that edge; no partial results kept.
- Widths: mm_count cannot exceed DEPTH, so no saturation is needed. idx wraps never (bounded by vec_count).

Test Plan:
- IN_W=8, OUT_W=8, SIG_W=8, POLY=8'h07, DEPTH=4, HOLD=1: load 1 vector, start, resp_a=resp_b=0 → done after 1 cycle, sig=8'hF9, mm_count=0, mm_found=0.
- Same parameters: load 2 vectors 8'hA5, 8'h3C, both responses 0 → stim shows A5 then 3C on consecutive cycles, sig=8'hF5, done on cycle 2.
- HOLD=3, 4 vectors loaded, resp_b = resp_a^1 only while stim==buf[2] → busy for 12 cycles, mm_count=1, mm_found=1, mm_idx=2.
- Load 5 vectors with DEPTH=4 → load_ready drops after the 4th handshake, vec_count=4, 5th word ignored; start on empty buffer after clear → stays IDLE, busy=0.
- Assert rst at cycle 2 of a 4-vector run → next cycle stim=0, busy=0, done=0, vec_count=0; a subsequent load plus start runs normally.
- Re-run from DONE with identical responses → identical sig. clear and start asserted together in IDLE → no run started.

Source files
------------

// File: rtl/fuzz_vector_player.sv
// Stimulus replay engine: buffers loaded vectors, drives them onto a DUT pair,
// compresses the identity response into a MISR and tracks response mismatches.
module fuzz_vector_player #(
    parameter int IN_W  = 63,
    parameter int OUT_W = 421,
    parameter int DEPTH = 32,
    parameter int HOLD  = 1,
    parameter int SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(32'h04C11DB7)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [IN_W-1:0]              load_data,
    input  logic                         clear,
    input  logic                         start,
    output logic [IN_W-1:0]              stim,
    input  logic [OUT_W-1:0]             resp_a,
    input  logic [OUT_W-1:0]             resp_b,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   vec_count,
    output logic [$clog2(DEPTH+1)-1:0]   mm_count,
    output logic                         mm_found,
    output logic [$clog2(DEPTH)-1:0]     mm_idx,
    output logic [SIG_W-1:0]             sig,
    output logic [1:0]                   state_dbg
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       vec_count_q, vec_count_d;
    logic [CW-1:0]       mm_count_q, mm_count_d;
    logic [IW-1:0]       idx_q, idx_d, mm_idx_q, mm_idx_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [IN_W-1:0]     stim_q, stim_d;
    logic [SIG_W-1:0]    sig_q, sig_d;
    logic                mm_found_q, mm_found_d;
    logic                busy_q, busy_d, done_q, done_d, load_ready_q, load_ready_d;
    logic                mem_we, go_run;
    logic [IN_W-1:0]     mem_q [DEPTH];

    logic [NCH*SIG_W-1:0] resp_pad;
    logic [SIG_W-1:0]     fold, misr;
    logic [IW-1:0]        idx_nxt;

    // Fold the wide response into SIG_W-bit chunks, top chunk zero-padded.
    always_comb begin
        resp_pad = '0;
        resp_pad[OUT_W-1:0] = resp_a;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ resp_pad[i*SIG_W +: SIG_W];
        end
        misr = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    end

    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        mm_count_d  = mm_count_q;
        mm_found_d  = mm_found_q;
        mm_idx_d    = mm_idx_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        stim_d      = stim_q;
        sig_d       = sig_q;
        mem_we      = 1'b0;
        go_run      = 1'b0;
        idx_nxt     = idx_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    vec_count_d = '0;
                end else begin
                    if (load_valid && load_ready_q) begin
                        mem_we      = 1'b1;
                        vec_count_d = vec_count_q + 1'b1;
                    end
                    if (start && (vec_count_q != '0)) go_run = 1'b1;
                end
            end
            S_RUN: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    sig_d = misr;
                    if (resp_a != resp_b) begin
                        mm_count_d = mm_count_q + 1'b1;
                        if (!mm_found_q) begin
                            mm_found_d = 1'b1;
                            mm_idx_d   = idx_q;
                        end
                    end
                    hold_d = '0;
                    if (CW'(idx_q) == vec_count_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        stim_d = mem_q[idx_nxt];
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d     = S_IDLE;
                    vec_count_d = '0;
                end else if (start) begin
                    go_run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go_run) begin
            state_d    = S_RUN;
            idx_d      = '0;
            hold_d     = '0;
            sig_d      = '1;
            mm_count_d = '0;
            mm_found_d = 1'b0;
            mm_idx_d   = '0;
            stim_d     = mem_q[0];
        end
        busy_d       = (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        load_ready_d = (state_d == S_IDLE) && (vec_count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_count_q  <= '0;
            mm_count_q   <= '0;
            mm_found_q   <= 1'b0;
            mm_idx_q     <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            stim_q       <= '0;
            sig_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            vec_count_q  <= vec_count_d;
            mm_count_q   <= mm_count_d;
            mm_found_q   <= mm_found_d;
            mm_idx_q     <= mm_idx_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            stim_q       <= stim_d;
            sig_q        <= sig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    // Buffer contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[vec_count_q[IW-1:0]] <= load_data;
    end

    assign load_ready = load_ready_q;
    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign vec_count  = vec_count_q;
    assign mm_count   = mm_count_q;
    assign mm_found   = mm_found_q;
    assign mm_idx     = mm_idx_q;
    assign sig        = sig_q;
    assign state_dbg  = state_q;
endmodule
